bcd_converter: RTL and testbench

- Sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) method, one bit per clock.
- Replaces the combinational divide/modulo digit chain that feeds the seven-segment rotator in the calculator top level.
- Generalised in operand width and digit count; adds a signed mode, an overflow flag and a leading-zero blank mask.
- Sits between control_unit (operand source) and DisplayRotator (digit sink).

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd_converter_if.sv | 27 ++
 rtl/bcd_digit_adj.sv | 13 +
 rtl/bcd_converter.sv | 132 +++++++++++++
 tb/tb_bcd_converter.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared types and elaboration-time helpers for the binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  // Decimal digits needed to hold any WIDTH-bit unsigned value:
  // floor(width * log10(2)) + 1, with log10(2) approximated as 0.30103.
  function automatic int bcd_digits(input int width);
    return (width * 30103) / 100000 + 1;
  endfunction

  // Width of a down-counter that must hold the value WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bcd_converter_if.sv
// Request/result bundle between the operand source and the BCD converter.
interface bcd_converter_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
);

  logic                  start;
  logic [WIDTH-1:0]      value;
  logic                  is_signed;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   digits;
  logic                  negative;
  logic                  overflow;
  logic [DIGITS-1:0]     blank_mask;

  modport master (
    output start, value, is_signed,
    input  busy, done, digits, negative, overflow, blank_mask
  );

  modport slave (
    input  start, value, is_signed,
    output busy, done, digits, negative, overflow, blank_mask
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble nibble correction: add 3 to any digit of 5 or more.
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // A digit >= 5 would carry past 9 after the next doubling; pre-bias it.
  always_comb begin
    dout = din;
    if (din >= 4'd5) dout = din + 4'd3;
  end

endmodule

// File: rtl/bcd_converter.sv
// Sequential binary-to-BCD converter, one bit per clock (shift-and-add-3).
module bcd_converter
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  bcd_converter_if.slave  bus
);

  localparam int BCD_RAW    = bcd_digits(WIDTH);
  localparam int BCD_DIGITS = (BCD_RAW > DIGITS) ? BCD_RAW : DIGITS;
  localparam int BCDW       = 4 * BCD_DIGITS;
  localparam int CW         = cnt_width(WIDTH);

  state_t              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [WIDTH-1:0]    mag_q, mag_d;
  logic [BCDW-1:0]     bcd_q, bcd_d;
  logic                sign_q, sign_d;
  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic                negative_q, negative_d;
  logic                overflow_q, overflow_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic                done_q, done_d;

  logic [BCDW-1:0]     bcd_adj;
  logic [DIGITS-1:0]   blank_w;
  logic                ovf_w;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (bcd_q[4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end

  if (BCD_DIGITS > DIGITS) begin : g_ovf
    assign ovf_w = |bcd_q[BCDW-1:4*DIGITS];
  end else begin : g_no_ovf
    assign ovf_w = 1'b0;
  end

  // Leading-zero mask: scan from the top digit down; digit 0 is never blanked.
  always_comb begin
    logic         zero_run;
    int unsigned  idx;
    zero_run = 1'b1;
    blank_w  = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      idx           = DIGITS - 1 - k;
      zero_run      = zero_run && (bcd_q[4*idx +: 4] == 4'd0);
      blank_w[idx]  = zero_run && (idx != 0);
    end
  end

  // Next-state and datapath: load on accept, shift WIDTH times, then publish.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    mag_d      = mag_q;
    bcd_d      = bcd_q;
    sign_d     = sign_q;
    digits_d   = digits_q;
    negative_d = negative_q;
    overflow_d = overflow_q;
    blank_d    = blank_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sign_d  = bus.is_signed && bus.value[WIDTH-1];
          mag_d   = sign_d ? (~bus.value + WIDTH'(1)) : bus.value;
          bcd_d   = '0;
          count_d = CW'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
        count_d        = count_q - CW'(1);
        if (count_q == CW'(1)) state_d = FINISH;
      end
      FINISH: begin
        digits_d   = bcd_q[4*DIGITS-1:0];
        negative_d = sign_q;
        overflow_d = ovf_w;
        blank_d    = blank_w;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      mag_q      <= '0;
      bcd_q      <= '0;
      sign_q     <= 1'b0;
      digits_q   <= '0;
      negative_q <= 1'b0;
      overflow_q <= 1'b0;
      blank_q    <= ~DIGITS'(1);
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      mag_q      <= mag_d;
      bcd_q      <= bcd_d;
      sign_q     <= sign_d;
      digits_q   <= digits_d;
      negative_q <= negative_d;
      overflow_q <= overflow_d;
      blank_q    <= blank_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.digits     = digits_q;
  assign bus.negative   = negative_q;
  assign bus.overflow   = overflow_q;
  assign bus.blank_mask = blank_q;

endmodule

// File: tb/tb_bcd_converter.sv
// Directed self-checking bench for bcd_converter (WIDTH=32, DIGITS=8).
module tb_bcd_converter;

  logic clk;
  logic reset_n;
  int   n_total;
  int   n_pass;

  bcd_converter_if #(.WIDTH(32), .DIGITS(8)) bus ();

  bcd_converter #(.WIDTH(32), .DIGITS(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Pulse start for one edge, scramble the inputs afterwards, wait for done.
  task automatic convert(input logic [31:0] v, input logic sgn,
                         output int lat, output int busy_n);
    bus.start     = 1'b1;
    bus.value     = v;
    bus.is_signed = sgn;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.value     = $urandom;
    bus.is_signed = ~sgn;
    busy_n = bus.busy ? 1 : 0;
    lat    = 0;
    while (!bus.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (bus.busy) busy_n++;
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, busy_n, dn;
    n_total = 0;
    n_pass  = 0;
    reset_n       = 1'b0;
    bus.start     = 1'b0;
    bus.value     = '0;
    bus.is_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  bus.busy, 0);
    check("rst_done",  bus.done, 0);
    check("rst_digits", bus.digits, 0);
    check("rst_neg",   bus.negative, 0);
    check("rst_ovf",   bus.overflow, 0);
    check("rst_blank", bus.blank_mask, 8'hFE);
    reset_n = 1'b1;
    @(posedge clk); #1;

    convert(32'd0, 1'b0, lat, busy_n);
    check("zero_lat",    lat, 33);
    check("zero_digits", bus.digits, 32'h00000000);
    check("zero_blank",  bus.blank_mask, 8'hFE);
    check("zero_ovf",    bus.overflow, 0);
    @(posedge clk); #1;
    check("zero_done_width", bus.done, 0);

    convert(32'd12345678, 1'b0, lat, busy_n);
    check("dec_lat",    lat, 33);
    check("dec_busy_n", busy_n, 33);
    check("dec_digits", bus.digits, 32'h12345678);
    check("dec_blank",  bus.blank_mask, 8'h00);
    check("dec_neg",    bus.negative, 0);
    repeat (5) @(posedge clk);
    #1;
    check("dec_hold", bus.digits, 32'h12345678);

    convert(32'hFFFFFFFF, 1'b1, lat, busy_n);
    check("m1_digits", bus.digits, 32'h00000001);
    check("m1_neg",    bus.negative, 1);
    check("m1_blank",  bus.blank_mask, 8'hFE);
    check("m1_ovf",    bus.overflow, 0);
    @(posedge clk); #1;

    convert(32'hFFFFFFFF, 1'b0, lat, busy_n);
    check("umax_digits", bus.digits, 32'h94967295);
    check("umax_ovf",    bus.overflow, 1);
    check("umax_neg",    bus.negative, 0);
    check("umax_blank",  bus.blank_mask, 8'h00);
    @(posedge clk); #1;

    convert(32'h80000000, 1'b1, lat, busy_n);
    check("min_digits", bus.digits, 32'h47483648);
    check("min_neg",    bus.negative, 1);
    check("min_ovf",    bus.overflow, 1);
    @(posedge clk); #1;

    // Start held high: each done cycle doubles as the next accept edge.
    bus.start     = 1'b1;
    bus.value     = 32'd42;
    bus.is_signed = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      bus.value = (i % 2 == 0) ? 32'd7 : 32'd42;
      wait_done(lat);
      check("b2b_lat", lat, 33);
      check("b2b_digits", bus.digits, (i % 2 == 0) ? 32'h42 : 32'h7);
      check("b2b_blank",  bus.blank_mask, (i % 2 == 0) ? 8'hFC : 8'hFE);
      if (i == 3) bus.start = 1'b0;
      @(posedge clk); #1;
      check("b2b_done_width", bus.done, 0);
      check("b2b_busy", bus.busy, (i < 3) ? 1 : 0);
      if (i < 3) bus.value = (i % 2 == 0) ? 32'd42 : 32'd7;
    end

    // Load a negative overflowing result so the reset clears something visible.
    convert(32'h80000000, 1'b1, lat, busy_n);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.value = 32'd555;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_busy",   bus.busy, 0);
    check("abort_done",   bus.done, 0);
    check("abort_digits", bus.digits, 0);
    check("abort_neg",    bus.negative, 0);
    check("abort_ovf",    bus.overflow, 0);
    check("abort_blank",  bus.blank_mask, 8'hFE);
    @(posedge clk); #1;
    reset_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) dn++;
    end
    check("abort_no_done", dn, 0);

    convert(32'd999, 1'b0, lat, busy_n);
    check("post_lat",    lat, 33);
    check("post_digits", bus.digits, 32'h00000999);
    check("post_blank",  bus.blank_mask, 8'hF8);
    check("post_neg",    bus.negative, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
